// File: rtl/nn_b2_serial_adder_pkg.sv
// Shared definitions for the bit-serial base-2 adder.
// Latency: n/a (constants and elaboration-time helpers only).
// Backpressure: n/a.
//
// Contents:
//    IDLE / SHIFT  - FSM state encodings (1-bit, legacy-compatible constants)
//    cnt_width()   - width of the bit counter for an N-bit operand

package nn_b2_serial_adder_pkg;

   // FSM state encodings
   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] SHIFT = 1'b1;

   // The bit counter must be able to hold N.
   function automatic int cnt_width(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/nn_b2_serial_adder_fa.sv
// Single-bit base-2 full adder used as the serial adder's datapath.
// Latency: purely combinational, zero cycles.
// Backpressure: none; there is no handshake.
//
// Ports:
//    x, y  in   addend bits
//    cin   in   carry in
//    s     out  sum bit, x ^ y ^ cin
//    cout  out  carry out, majority(x, y, cin)

module b2_full_adder (
   input  logic x,
   input  logic y,
   input  logic cin,
   output logic s,
   output logic cout
);

   assign s    = x ^ y ^ cin;
   assign cout = (x & y) | (x & cin) | (y & cin);

endmodule

// File: rtl/nn_b2_serial_adder.sv
// Bit-serial adder: computes x + y + cin LSB first using one full adder and a carry flop.
// Latency: soc accepted at edge k; result valid and eoc high after edge k+N (eoc low N cycles).
// Backpressure: soc is ignored while busy (eoc=0); the controller must wait for eoc.
//
// Ports:
//    clock  in   system clock, rising edge
//    reset  in   asynchronous, active-high reset
//    soc    in   start request, accepted only while idle
//    x, y   in   N-bit operands, sampled on the accepting edge
//    cin    in   carry in, sampled on the accepting edge
//    eoc    out  1 = idle with s/cout valid, 0 = busy
//    s      out  last completed sum (mod 2^N)
//    cout   out  last completed carry out of bit N-1

module nn_b2_serial_adder
   import nn_b2_serial_adder_pkg::*;
#(
   parameter  int N     = 4,
   localparam int CNT_W = cnt_width(N)
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         soc,
   input  logic [N-1:0] x,
   input  logic [N-1:0] y,
   input  logic         cin,
   output logic         eoc,
   output logic [N-1:0] s,
   output logic         cout
);

   logic [0:0]       state;
   logic [CNT_W-1:0] cnt;
   logic [N-1:0]     xr;
   logic [N-1:0]     yr;
   logic [N-1:0]     sr;
   logic             c;
   logic [N-1:0]     s_q;
   logic             cout_q;

   logic             fa_s;
   logic             fa_c;
   logic             last_bit;
   logic [N-1:0]     sr_next;

   b2_full_adder u_fa (
      .x    (xr[0]),
      .y    (yr[0]),
      .cin  (c),
      .s    (fa_s),
      .cout (fa_c)
   );

   // Sum bits enter at the MSB and walk down, so after N shifts bit 0 of the
   // result has arrived in sr[0].
   assign sr_next  = {fa_s, sr[N-1:1]};
   assign last_bit = (cnt == CNT_W'(N - 1));

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state  <= IDLE;
         cnt    <= '0;
         xr     <= '0;
         yr     <= '0;
         sr     <= '0;
         c      <= 1'b0;
         s_q    <= '0;
         cout_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (soc) begin
                  xr    <= x;
                  yr    <= y;
                  c     <= cin;
                  sr    <= '0;
                  cnt   <= '0;
                  state <= SHIFT;
               end
            end
            SHIFT: begin
               sr  <= sr_next;
               xr  <= {1'b0, xr[N-1:1]};
               yr  <= {1'b0, yr[N-1:1]};
               c   <= fa_c;
               cnt <= cnt + CNT_W'(1);
               // Publish the result only once it is complete, so the previous
               // result stays readable for the whole busy period.
               if (last_bit) begin
                  s_q    <= sr_next;
                  cout_q <= fa_c;
                  state  <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign eoc  = (state == IDLE);
   assign s    = s_q;
   assign cout = cout_q;

endmodule

// File: tb/tb_nn_b2_serial_adder.sv
// Self-checking bench for nn_b2_serial_adder at N=4 and N=8.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).

module tb_nn_b2_serial_adder;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       soc4  = 1'b0;
   logic       soc8  = 1'b0;
   logic [7:0] x     = '0;
   logic [7:0] y     = '0;
   logic       cin   = 1'b0;

   logic       eoc4, eoc8;
   logic [3:0] s4;
   logic [7:0] s8;
   logic       cout4, cout8;

   int n_vec = 0;
   int n_err = 0;

   always #5 clock = ~clock;

   nn_b2_serial_adder #(.N(4)) dut4 (
      .clock (clock),
      .reset (reset),
      .soc   (soc4),
      .x     (x[3:0]),
      .y     (y[3:0]),
      .cin   (cin),
      .eoc   (eoc4),
      .s     (s4),
      .cout  (cout4)
   );

   nn_b2_serial_adder #(.N(8)) dut8 (
      .clock (clock),
      .reset (reset),
      .soc   (soc8),
      .x     (x),
      .y     (y),
      .cin   (cin),
      .eoc   (eoc8),
      .s     (s8),
      .cout  (cout8)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Wait for dut4 to go idle; returns the number of edges waited.
   task automatic wait4(output int cyc);
      cyc = 0;
      while (!eoc4 && cyc < 40) begin
         tick();
         cyc++;
      end
      if (cyc >= 40) check("wait4_timeout", 32'(cyc), 32'(39));
   endtask

   task automatic wait_both();
      int cyc;
      cyc = 0;
      while (!(eoc4 && eoc8) && cyc < 40) begin
         tick();
         cyc++;
      end
      if (cyc >= 40) check("wait_both_timeout", 32'(cyc), 32'(39));
   endtask

   // Single-cycle start pulse on dut4.
   task automatic start4(input logic [3:0] xa, input logic [3:0] ya, input logic ci);
      x    = {4'h0, xa};
      y    = {4'h0, ya};
      cin  = ci;
      soc4 = 1'b1;
      tick();
      soc4 = 1'b0;
   endtask

   initial begin
      int         cyc;
      logic [4:0] exp4;
      logic [8:0] exp8;
      logic [3:0] prev4;

      // Reset state
      #1;
      check("rst_eoc4",  32'(eoc4),  32'(1));
      check("rst_s4",    32'(s4),    32'(0));
      check("rst_cout4", 32'(cout4), 32'(0));
      check("rst_eoc8",  32'(eoc8),  32'(1));
      check("rst_s8",    32'(s8),    32'(0));
      tick();
      reset = 1'b0;
      tick();

      // Basic 5 + 3 with busy-time measurement and idle hold
      start4(4'd5, 4'd3, 1'b0);
      check("basic_busy", 32'(eoc4), 32'(0));
      wait4(cyc);
      check("basic_cycles", 32'(cyc),   32'(4));
      check("basic_s",      32'(s4),    32'(8));
      check("basic_cout",   32'(cout4), 32'(0));
      repeat (10) tick();
      check("hold_s",    32'(s4),    32'(8));
      check("hold_cout", 32'(cout4), 32'(0));
      check("hold_eoc",  32'(eoc4),  32'(1));

      // Reset mid-operation abandons the addition and clears the result
      start4(4'hF, 4'h1, 1'b0);
      tick();
      check("mid_busy",  32'(eoc4), 32'(0));
      check("mid_old_s", 32'(s4),   32'(8));
      #1 reset = 1'b1;
      #1;
      check("arst_eoc",  32'(eoc4),  32'(1));
      check("arst_s",    32'(s4),    32'(0));
      check("arst_cout", 32'(cout4), 32'(0));
      tick();
      reset = 1'b0;
      repeat (3) tick();
      check("post_rst_eoc",  32'(eoc4),  32'(1));
      check("post_rst_s",    32'(s4),    32'(0));
      check("post_rst_cout", 32'(cout4), 32'(0));

      // Carry chain and overflow
      start4(4'hF, 4'h0, 1'b1);
      wait4(cyc);
      check("ovf1_s",    32'(s4),    32'(0));
      check("ovf1_cout", 32'(cout4), 32'(1));
      start4(4'hF, 4'hF, 1'b1);
      wait4(cyc);
      check("ovf2_s",    32'(s4),    32'(15));
      check("ovf2_cout", 32'(cout4), 32'(1));

      // soc while busy and operand changes after acceptance are ignored
      start4(4'd2, 4'd2, 1'b0);
      x    = 8'd7;
      y    = 8'd7;
      soc4 = 1'b1;
      tick();
      soc4 = 1'b0;
      cyc  = 0;
      while (!eoc4 && cyc < 40) begin
         x   = 8'($urandom);
         y   = 8'($urandom);
         cin = 1'($urandom);
         tick();
         cyc++;
      end
      if (cyc >= 40) check("busy_timeout", 32'(cyc), 32'(39));
      check("busy_s",    32'(s4),    32'(4));
      check("busy_cout", 32'(cout4), 32'(0));
      repeat (2) tick();
      check("busy_no_second", 32'(eoc4), 32'(1));
      check("busy_s_hold",    32'(s4),   32'(4));

      // Back-to-back with soc held high
      x    = 8'd1;
      y    = 8'd1;
      cin  = 1'b0;
      soc4 = 1'b1;
      tick();
      x = 8'd6;
      y = 8'd9;
      wait4(cyc);
      check("b2b_first_s", 32'(s4),   32'(2));
      check("b2b_eoc_hi",  32'(eoc4), 32'(1));
      tick();
      check("b2b_eoc_one_cycle", 32'(eoc4), 32'(0));
      check("b2b_old_s_kept",    32'(s4),   32'(2));
      soc4 = 1'b0;
      wait4(cyc);
      check("b2b_second_s",    32'(s4),    32'(15));
      check("b2b_second_cout", 32'(cout4), 32'(0));

      // Random operands at N=4 and N=8 against plain integer addition
      wait_both();
      for (int i = 0; i < 1000; i++) begin
         prev4 = s4;
         x     = 8'($urandom);
         y     = 8'($urandom);
         cin   = 1'($urandom);
         exp4  = 5'(x[3:0]) + 5'(y[3:0]) + 5'(cin);
         exp8  = 9'(x) + 9'(y) + 9'(cin);
         soc4  = 1'b1;
         soc8  = 1'b1;
         tick();
         soc4 = 1'b0;
         soc8 = 1'b0;
         check("rnd_s4_held", 32'(s4), 32'(prev4));
         x = 8'($urandom);
         y = 8'($urandom);
         wait_both();
         check("rnd_sum4", 32'({cout4, s4}), 32'(exp4));
         check("rnd_sum8", 32'({cout8, s8}), 32'(exp8));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
